// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the two buses of the instruction-memory loader:
//   - the serial byte stream (valid/ready handshake) that carries the program
//   - the instruction-memory write port (strobe, word address, word data)
// Modport "master" is the loader's view: it consumes the byte stream and
// drives the memory write port. Modport "slave" is the surrounding system:
// it drives the byte stream and receives the memory writes.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int ADDR_W = 8
);

   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;

   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads a program into instruction memory from a serial byte stream and
// holds the downstream processor in reset until the load has completed.
//
// Stream format: 16-bit word count N (high byte first), then 4*N data bytes.
// Each group of 4 bytes is assembled into a 32-bit word (byte order set by
// BIG_ENDIAN) and written to consecutive word addresses starting at 0.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a one-byte
// XOR checksum to the stream. The checksum covers both length bytes and all
// data bytes; a mismatch sends the loader to ERR instead of DONE. With the
// macro undefined, the CSUM state and accumulator are not built and the
// last word goes straight to DONE.
//
// Word counts above 2^ADDR_W are rejected right after the length is read.
// ADDR_W is expected to be at most 16 (the length field is 16 bits wide).
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W     = 8,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic          clk,
   input  logic          R,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          core_reset,
   output logic          done,
   output logic          error
);

   // Largest acceptable word count: the whole address space.
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE,
      ERR
   } state_t;

   state_t            state;
   state_t            state_next;
   state_t            after_data;

   logic [15:0]       len_q;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_cnt;
   logic [1:0]        lane;
   logic [31:0]       wdata_q;

   logic              xfer;
   logic              restart;
   logic [16:0]       len_rx;
   logic              len_too_long;
   logic              len_zero;
   logic              last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
   logic              csum_ok;
`endif

   // A byte moves only when both sides agree in the same cycle.
   assign xfer = bus.byte_valid & bus.byte_ready;

   // start is honoured only where a new load may begin; everywhere else it
   // is ignored so a stray pulse cannot corrupt a load in progress.
   assign restart = start & ((state == IDLE) | (state == DONE) | (state == ERR));

   // Full 16-bit count as it will look once the low byte on the bus is taken.
   // One extra bit keeps the comparison against 2^ADDR_W exact.
   assign len_rx       = {1'b0, len_q[15:8], bus.byte_data};
   assign len_too_long = (len_rx > MAX_WORDS);
   assign len_zero     = (len_rx == 17'd0);

   // The current word is the last one when index+1 reaches N. The index is
   // widened first so a full-size load (N = 2^ADDR_W) is detected without
   // the index itself ever having to wrap.
   assign last_word = ((17'(word_idx) + 17'd1) == {1'b0, len_q});

   // Byte lane for the incoming data byte: big-endian fills from [31:24]
   // downwards, little-endian fills from [7:0] upwards.
   assign lane = BIG_ENDIAN ? ~byte_cnt : byte_cnt;

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign after_data = CSUM;
   assign csum_ok    = (bus.byte_data == csum_q);
`else
   assign after_data = DONE;
`endif

   // The memory port always shows the current word index and assembled
   // word; the write strobe alone decides when they are meaningful.
   assign bus.imem_addr  = word_idx;
   assign bus.imem_wdata = wdata_q;

   // State register; reset parks the loader in IDLE.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: every accepting state waits for a transfer, so an
   // idle stream (byte_valid low) simply holds the current state.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               state_next = LEN_LO;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               if (len_too_long) begin
                  state_next = ERR;
               end else if (len_zero) begin
                  state_next = after_data;
               end else begin
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (xfer && (byte_cnt == 2'd3)) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            state_next = last_word ? after_data : DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (xfer) begin
               state_next = csum_ok ? DONE : ERR;
            end
         end
`endif
         DONE, ERR: begin
            if (start) begin
               state_next = LEN_HI;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode: purely from state, so the handshake and strobes follow
   // the FSM with no extra latency and clear as soon as reset asserts.
   always_comb begin
      bus.byte_ready = 1'b0;
      bus.imem_we    = 1'b0;
      core_reset     = 1'b1;
      done           = 1'b0;
      error          = 1'b0;
      case (state)
         LEN_HI, LEN_LO, DATA: begin
            bus.byte_ready = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            bus.byte_ready = 1'b1;
         end
`endif
         WRITE: begin
            bus.imem_we = 1'b1;
         end
         DONE: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         ERR: begin
            error = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Length capture: high byte in LEN_HI, low byte in LEN_LO.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         len_q <= 16'd0;
      end else if (restart) begin
         len_q <= 16'd0;
      end else if (xfer && (state == LEN_HI)) begin
         len_q[15:8] <= bus.byte_data;
      end else if (xfer && (state == LEN_LO)) begin
         len_q[7:0] <= bus.byte_data;
      end
   end

   // Word assembly: each accepted data byte lands in its lane and advances
   // the 2-bit byte counter, which wraps to 0 after the fourth byte.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         byte_cnt <= 2'd0;
         wdata_q  <= 32'd0;
      end else if (restart) begin
         byte_cnt <= 2'd0;
      end else if (xfer && (state == DATA)) begin
         byte_cnt <= byte_cnt + 2'd1;
         case (lane)
            2'd0: wdata_q[7:0]   <= bus.byte_data;
            2'd1: wdata_q[15:8]  <= bus.byte_data;
            2'd2: wdata_q[23:16] <= bus.byte_data;
            2'd3: wdata_q[31:24] <= bus.byte_data;
         endcase
      end
   end

   // Word index: advances after each write while words remain; it is left
   // on the final address rather than wrapping past the end of memory.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         word_idx <= '0;
      end else if (restart) begin
         word_idx <= '0;
      end else if ((state == WRITE) && !last_word) begin
         word_idx <= word_idx + ADDR_W'(1);
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running XOR of every length and data byte; the checksum byte itself is
   // compared against this value and never folded into it.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         csum_q <= 8'd0;
      end else if (restart) begin
         csum_q <= 8'd0;
      end else if (xfer && (state inside {LEN_HI, LEN_LO, DATA})) begin
         csum_q <= csum_q ^ bus.byte_data;
      end
   end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Drives two loaders (big- and little-endian) with the same byte stream and
// scores every memory write against words queued when the bytes are sent.
// Follows IMEM_LOADER_CHECKSUM_EN so the same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam int ADDR_W = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic        clk = 1'b0;
   logic        R;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        core_reset_be, done_be, error_be;
   logic        core_reset_le, done_le, error_le;

   int          passed = 0;
   int          failed = 0;
   int          total = 0;
   int          writes_be = 0;
   int          writes_le = 0;
   int          snap_be;
   int          snap_le;
   wr_t         exp_be[$];
   wr_t         exp_le[$];
   logic [31:0] words_q[$];
   logic [7:0]  csum_model;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus_be ();
   imem_loader_if #(.ADDR_W(ADDR_W)) bus_le ();

   assign bus_be.byte_valid = byte_valid;
   assign bus_be.byte_data  = byte_data;
   assign bus_le.byte_valid = byte_valid;
   assign bus_le.byte_data  = byte_data;

   imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut_be (
      .clk        (clk),
      .R          (R),
      .start      (start),
      .bus        (bus_be),
      .core_reset (core_reset_be),
      .done       (done_be),
      .error      (error_be)
   );

   imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) dut_le (
      .clk        (clk),
      .R          (R),
      .start      (start),
      .bus        (bus_le),
      .core_reset (core_reset_le),
      .done       (done_le),
      .error      (error_le)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Hard stop in case a handshake never completes.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Queue the words both loaders should write for one program word.
   task automatic push_word(input int idx, input logic [31:0] w);
      wr_t e;
      e.addr = ADDR_W'(idx);
      e.data = w;
      exp_be.push_back(e);
      e.data = {w[7:0], w[15:8], w[23:16], w[31:24]};
      exp_le.push_back(e);
   endtask

   // Score any write strobe visible this cycle against the queues.
   task automatic observe();
      wr_t e;
      if (bus_be.imem_we === 1'b1) begin
         writes_be++;
         check("be_write_expected", 32'(exp_be.size() > 0), 1);
         if (exp_be.size() > 0) begin
            e = exp_be.pop_front();
            check("be_addr", 32'(bus_be.imem_addr), 32'(e.addr));
            check("be_wdata", bus_be.imem_wdata, e.data);
         end
         check("be_ready_in_write", 32'(bus_be.byte_ready), 0);
      end
      if (bus_le.imem_we === 1'b1) begin
         writes_le++;
         check("le_write_expected", 32'(exp_le.size() > 0), 1);
         if (exp_le.size() > 0) begin
            e = exp_le.pop_front();
            check("le_addr", 32'(bus_le.imem_addr), 32'(e.addr));
            check("le_wdata", bus_le.imem_wdata, e.data);
         end
      end
   endtask

   // Advance one clock; outputs are sampled 1 unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      observe();
   endtask

   // Offer one byte until it is taken; optionally idle a cycle afterwards.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int waited = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while ((bus_be.byte_ready !== 1'b1) && (waited < 16)) begin
         step();
         waited++;
      end
      if (waited == 16) begin
         check("byte_ready_wait", 32'(bus_be.byte_ready), 1);
      end
      csum_model = csum_model ^ b;
      step();
      byte_valid = 1'b0;
      byte_data  = 8'hEE;
      if (gap) begin
         step();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap, input bit poke_start);
      for (int bi = 0; bi < 4; bi++) begin
         send_byte(w[31-8*bi -: 8], gap);
         if (poke_start && (bi == 1)) begin
            start = 1'b1;
            step();
            start = 1'b0;
         end
      end
   endtask

   // Full load of words_q with word count len, ending in DONE or ERR.
   task automatic load(input logic [15:0] len, input bit gap, input bit bad_csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] cbyte;
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      check("core_reset_on_start", 32'(core_reset_be), 1);
      csum_model = 8'd0;
      send_byte(len[15:8], gap);
      send_byte(len[7:0], gap);
      for (int wi = 0; wi < words_q.size(); wi++) begin
         push_word(wi, words_q[wi]);
         send_word(words_q[wi], gap, gap && (wi == 0));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      cbyte = bad_csum ? (csum_model ^ 8'h01) : csum_model;
      send_byte(cbyte, 1'b0);
`else
      if (len != 16'd0) begin
         step();
      end
`endif
      check("end_done_be", 32'(done_be), 32'(!bad_csum));
      check("end_error_be", 32'(error_be), 32'(bad_csum));
      check("end_core_reset_be", 32'(core_reset_be), 32'(bad_csum));
      check("end_done_le", 32'(done_le), 32'(!bad_csum));
      check("end_core_reset_le", 32'(core_reset_le), 32'(bad_csum));
      check("be_queue_drained", 32'(exp_be.size()), 0);
      check("le_queue_drained", 32'(exp_le.size()), 0);
   endtask

   task automatic check_reset_outputs(input string p);
      check({p, "_ready"}, 32'(bus_be.byte_ready), 0);
      check({p, "_we"}, 32'(bus_be.imem_we), 0);
      check({p, "_addr"}, 32'(bus_be.imem_addr), 0);
      check({p, "_wdata_be"}, bus_be.imem_wdata, 0);
      check({p, "_wdata_le"}, bus_le.imem_wdata, 0);
      check({p, "_core_reset"}, 32'(core_reset_be), 1);
      check({p, "_core_reset_le"}, 32'(core_reset_le), 1);
      check({p, "_done"}, 32'(done_be), 0);
      check({p, "_error"}, 32'(error_be | error_le), 0);
   endtask

   initial begin
      R          = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;

      // Reset asserted with start held high: nothing may move.
      #2;
      R     = 1'b0;
      start = 1'b1;
      #1;
      check_reset_outputs("por");
      #13;
      check("por_hold_ready", 32'(bus_be.byte_ready), 0);
      start = 1'b0;
      #1;
      R = 1'b1;
      step();
      check("idle_ready", 32'(bus_be.byte_ready), 0);
      check("idle_core_reset", 32'(core_reset_be), 1);

      // Single word, both byte orders, back-to-back bytes.
      $display("[TB] single word load");
      words_q.delete();
      words_q.push_back(32'h2008_0005);
      load(16'd1, 1'b0, 1'b0);

      // Two words with idle cycles between bytes and a stray start pulse.
      $display("[TB] two words, gapped stream");
      words_q.delete();
      words_q.push_back(32'h1122_3344);
      words_q.push_back(32'hCAFE_F00D);
      load(16'd2, 1'b1, 1'b0);

      // Word count one past the address space is rejected.
      $display("[TB] oversize length");
      snap_be = writes_be;
      snap_le = writes_le;
      start = 1'b1;
      step();
      start = 1'b0;
      check("err_core_reset_on_start", 32'(core_reset_be), 1);
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check("err_error", 32'(error_be), 1);
      check("err_error_le", 32'(error_le), 1);
      check("err_core_reset", 32'(core_reset_be), 1);
      check("err_done", 32'(done_be), 0);
      check("err_ready", 32'(bus_be.byte_ready), 0);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (3) step();
      byte_valid = 1'b0;
      check("err_stays", 32'(error_be), 1);
      check("err_no_writes_be", 32'(writes_be), 32'(snap_be));
      check("err_no_writes_le", 32'(writes_le), 32'(snap_le));

      // Full address space: last index 2^ADDR_W-1 written, no wrap.
      $display("[TB] full-size load");
      snap_be = writes_be;
      words_q.delete();
      for (int i = 0; i < 256; i++) begin
         words_q.push_back({8'(i), ~8'(i), 8'h3C, 8'(i) ^ 8'hA5});
      end
      load(16'd256, 1'b0, 1'b0);
      check("full_write_count", 32'(writes_be - snap_be), 256);
      check("full_final_addr", 32'(bus_be.imem_addr), 255);

      // Empty program.
      $display("[TB] zero-length load");
      words_q.delete();
      load(16'd0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Known checksum 0x2C passes; 0x2D must fail.
      $display("[TB] checksum good and bad");
      words_q.delete();
      words_q.push_back(32'h2008_0005);
      load(16'd1, 1'b0, 1'b0);
      check("csum_model_value", 32'(csum_model ^ 8'h2C), 32'h2C);
      load(16'd1, 1'b0, 1'b1);
`endif

      // Reset in the middle of the second word, then a clean reload.
      $display("[TB] reset mid-load");
      start = 1'b1;
      step();
      start = 1'b0;
      csum_model = 8'd0;
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      push_word(0, 32'h1357_9BDF);
      send_word(32'h1357_9BDF, 1'b0, 1'b0);
      step();
      send_byte(8'hA1, 1'b0);
      send_byte(8'hB2, 1'b0);
      #2;
      R = 1'b0;
      #1;
      check_reset_outputs("midload");
      #3;
      R = 1'b1;
      step();
      check("post_reset_idle_ready", 32'(bus_be.byte_ready), 0);
      check("post_reset_idle_done", 32'(done_be), 0);
      words_q.delete();
      words_q.push_back(32'hFEDC_BA98);
      load(16'd1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1: 1 places the first byte of a word in [31:24], 0 places it in [7:0].
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; R input 1, asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse to begin a load.
REQ-005 byte_valid  input  1  byte_data holds a valid byte.
REQ-006 byte_data  input  8  serial program byte.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_addr  output  ADDR_W  word address.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 core_reset  output  1  active-high reset to the downstream processor.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  load aborted.

Function
REQ-014 The FSM SHALL have states IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE and ERR.
REQ-015 In IDLE, start SHALL move the FSM to LEN_HI on the next edge; start SHALL be ignored in every other state except DONE and ERR.
REQ-016 LEN_HI and LEN_LO SHALL each accept one byte, forming a 16-bit word count N, high byte first.
REQ-017 After LEN_LO, the next state SHALL be:
- ERR if N > 2^ADDR_W;
- CSUM if N = 0 (or DONE when checksum is compiled out);
- DATA otherwise.
REQ-018 DATA SHALL accept 4 bytes per word, tracked by a 2-bit byte counter, and assemble them per BIG_ENDIAN.
REQ-019 On the 4th byte, the FSM SHALL enter WRITE.
REQ-020 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr = word index (starting at 0) and imem_wdata = the assembled word.
REQ-021 After WRITE, the word index SHALL increment; the FSM SHALL return to DATA if words remain, else go to CSUM (or DONE).
REQ-022 byte_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA and CSUM, and 0 in all other states, including WRITE.
REQ-023 When byte_valid=0 in an accepting state, the FSM and all counters SHALL hold.
REQ-024 imem_we SHALL be 0 outside WRITE.
REQ-025 core_reset SHALL be 1 in every state except DONE.
REQ-026 done SHALL be 1 only in DONE.
REQ-027 error SHALL be 1 only in ERR.
REQ-028 In DONE or ERR, start SHALL clear the word index and byte counter and enter LEN_HI; core_reset SHALL re-assert on that same edge.
REQ-029 A word index reaching 2^ADDR_W-1 SHALL be written, and the index SHALL NOT wrap within one load.
REQ-030 byte_data SHALL be sampled only on a transfer cycle.

Reset
REQ-031 Asserting R low SHALL immediately, regardless of clk, force:
- state=IDLE;
- byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
- core_reset=1, done=0, error=0;
- all counters, N and the checksum accumulator to 0.
REQ-032 R asserted mid-load SHALL abandon the load; already-written words SHALL NOT be rewritten or erased.
REQ-033 Reset release SHALL be synchronous to clk; the first state change SHALL be no earlier than the first rising edge after R goes high.

Configuration
REQ-034 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL XOR-accumulate every accepted byte (both length bytes and all data bytes) into an 8-bit register.
REQ-035 With IMEM_LOADER_CHECKSUM_EN defined, CSUM SHALL accept one byte and go to DONE if that byte equals the accumulator, else go to ERR.
REQ-036 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and the accumulator SHALL be absent, and the final WRITE (or N=0) SHALL go directly to DONE.

Verification
REQ-037 Scenario: start; bytes 00 01 20 08 00 05 (BIG_ENDIAN=1, no checksum) -> one imem_we pulse, addr 0, wdata 0x20080005; done=1 and core_reset=0 one cycle after WRITE.
REQ-038 Scenario: same stream with BIG_ENDIAN=0 -> wdata 0x05000820.
REQ-039 Scenario: N=2 with byte_valid toggling every other cycle -> two writes, addr 0 then 1, correct data; byte_ready=0 during each WRITE; no byte lost or duplicated.
REQ-040 Scenario: N=0x0101 with ADDR_W=8 -> ERR after LEN_LO, error=1, core_reset=1, imem_we never asserted.
REQ-041 Scenario (CHECKSUM_EN): stream 00 01 20 08 00 05 then checksum 0x2C -> DONE; checksum 0x2D -> ERR.
REQ-042 Scenario: R pulled low after 2 data bytes -> outputs take reset values immediately; a new start plus a full stream then loads correctly from addr 0.
